// File: rtl/rram_ctrl_pkg.sv
// Shared definitions for the RRAM macro sequencer.
//   state_t        : sequencer states S0..S10
//   CMD_*          : two-phase host command codes
//   ctrl_out_t     : Moore output bundle decoded from a state
//   decode_outputs : state -> Moore outputs
package rram_ctrl_pkg;

  typedef enum logic [3:0] {
    S0_IDLE        = 4'd0,
    S1_READ_ADDR   = 4'd1,
    S2_WRITE_ADDR  = 4'd2,
    S3_FORM_ADDR   = 4'd3,
    S4_WRITE_CACHE = 4'd4,
    S5_FORM_CONF   = 4'd5,
    S6_FORM_EXEC   = 4'd6,
    S7_WRITE_CONF  = 4'd7,
    S8_WRITE_EXEC  = 4'd8,
    S9_READ_CONF   = 4'd9,
    S10_READ_EXEC  = 4'd10
  } state_t;

  localparam logic [3:0] CMD_READ1  = 4'b0011;
  localparam logic [3:0] CMD_READ2  = 4'b0010;
  localparam logic [3:0] CMD_WRITE1 = 4'b0101;
  localparam logic [3:0] CMD_WRITE2 = 4'b0100;
  localparam logic [3:0] CMD_FORM1  = 4'b0111;
  localparam logic [3:0] CMD_FORM2  = 4'b0110;

  typedef struct packed {
    logic we;
    logic re;
    logic form;
    logic en_dec;
    logic en_sc;
    logic rb;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outputs(state_t s);
    ctrl_out_t o;
    o        = '0;
    o.rb     = 1'b1;
    o.we     = (s == S8_WRITE_EXEC);
    o.re     = (s == S10_READ_EXEC);
    o.form   = (s == S6_FORM_EXEC);
    o.en_dec = (s == S1_READ_ADDR) || (s == S2_WRITE_ADDR) || (s == S3_FORM_ADDR) ||
               (s == S6_FORM_EXEC) || (s == S8_WRITE_EXEC) || (s == S10_READ_EXEC);
    o.en_sc  = (s == S4_WRITE_CACHE) || (s == S6_FORM_EXEC) || (s == S8_WRITE_EXEC);
    if ((s == S4_WRITE_CACHE) || (s == S6_FORM_EXEC) ||
        (s == S8_WRITE_EXEC) || (s == S10_READ_EXEC))
      o.rb = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/rram_control_if.sv
// Host-side pin bundle of the RRAM macro.
//   master : host (drives CE/ALE/CLE/command/ready inputs, sees strobes and RB)
//   slave  : rram_control sequencer
interface rram_control_if;
  logic       CE;
  logic       ALE;
  logic       CLE;
  logic [3:0] command;
  logic       address_ready;
  logic       command_ready;
  logic       WE_L;
  logic       RE_L;
  logic       RB;

  modport master (
    output CE, ALE, CLE, command, address_ready, command_ready,
    input  WE_L, RE_L, RB
  );

  modport slave (
    input  CE, ALE, CLE, command, address_ready, command_ready,
    output WE_L, RE_L, RB
  );
endinterface

// File: rtl/rram_control.sv
// Top-level sequencing FSM of the RRAM macro.
// Decodes two-phase host commands (read / write / forming) and drives the
// datapath enables, address decoder, pulse counter and the ready/busy line.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   host (slave)        : CE, ALE, CLE, command, address_ready, command_ready
//                         in; WE_L, RE_L, RB out
//   cache_count_flag    : write cache full
//   forming_count_flag  : forming pulses done
//   write_count_flag    : write pulses done
//   we/re/forming_writeread, en_decoder, en_state_count : registered enables
module rram_control
  import rram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rram_control_if.slave      host,
  input  logic               cache_count_flag,
  input  logic               forming_count_flag,
  input  logic               write_count_flag,
  output logic               we_writeread,
  output logic               re_writeread,
  output logic               forming_writeread,
  output logic               en_decoder,
  output logic               en_state_count
);

  state_t    state;
  state_t    state_next;
  ctrl_out_t out_q;

  always_comb begin
    state_next = state;
    unique case (state)
      S0_IDLE: begin
        if (host.command == CMD_READ1)       state_next = S1_READ_ADDR;
        else if (host.command == CMD_WRITE1) state_next = S2_WRITE_ADDR;
        else if (host.command == CMD_FORM1)  state_next = S3_FORM_ADDR;
      end
      S1_READ_ADDR:   if (host.address_ready)         state_next = S9_READ_CONF;
      S2_WRITE_ADDR:  if (host.address_ready)         state_next = S4_WRITE_CACHE;
      S3_FORM_ADDR:   if (host.address_ready)         state_next = S5_FORM_CONF;
      S4_WRITE_CACHE: if (cache_count_flag)           state_next = S7_WRITE_CONF;
      S5_FORM_CONF:   if (host.command == CMD_FORM2)  state_next = S6_FORM_EXEC;
      S7_WRITE_CONF:  if (host.command == CMD_WRITE2) state_next = S8_WRITE_EXEC;
      S9_READ_CONF:   if (host.command == CMD_READ2)  state_next = S10_READ_EXEC;
      S6_FORM_EXEC:   if (forming_count_flag)         state_next = S0_IDLE;
      S8_WRITE_EXEC:  if (write_count_flag)           state_next = S0_IDLE;
      S10_READ_EXEC:  if (host.command_ready)         state_next = S0_IDLE;
      default:                                        state_next = S0_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they change on
  // the same edge as the state register and stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0_IDLE;
      out_q <= decode_outputs(S0_IDLE);
    end else if (host.CE) begin
      state <= S0_IDLE;
      out_q <= decode_outputs(S0_IDLE);
    end else begin
      state <= state_next;
      out_q <= decode_outputs(state_next);
    end
  end

  assign we_writeread      = out_q.we;
  assign re_writeread      = out_q.re;
  assign forming_writeread = out_q.form;
  assign en_decoder        = out_q.en_dec;
  assign en_state_count    = out_q.en_sc;
  assign host.RB           = out_q.rb;

  assign host.WE_L = ~(~host.CE & host.CLE);
  assign host.RE_L = ~(~host.CE & host.ALE &
                       ((state == S1_READ_ADDR) || (state == S2_WRITE_ADDR) ||
                        (state == S3_FORM_ADDR)));

endmodule

// File: tb/tb_rram_control.sv
module tb_rram_control;

  logic clk;
  logic rst_n;
  logic cache_count_flag, forming_count_flag, write_count_flag;
  logic we_writeread, re_writeread, forming_writeread, en_decoder, en_state_count;

  rram_control_if host ();

  rram_control dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host              (host.slave),
    .cache_count_flag  (cache_count_flag),
    .forming_count_flag(forming_count_flag),
    .write_count_flag  (write_count_flag),
    .we_writeread      (we_writeread),
    .re_writeread      (re_writeread),
    .forming_writeread (forming_writeread),
    .en_decoder        (en_decoder),
    .en_state_count    (en_state_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bits: {we, re, form, en_dec, en_sc, RB, WE_L, RE_L}
  typedef struct {
    logic       ce, ale, cle;
    logic [3:0] cmd;
    logic       ar, cr, ccf, fcf, wcf;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] observed();
    return {we_writeread, re_writeread, forming_writeread, en_decoder,
            en_state_count, host.RB, host.WE_L, host.RE_L};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic ce, logic ale, logic cle, logic [3:0] cmd,
                              logic ar, logic cr, logic ccf, logic fcf, logic wcf,
                              logic [5:0] st, logic wel, logic rel);
    vec_t v;
    v.ce = ce; v.ale = ale; v.cle = cle; v.cmd = cmd;
    v.ar = ar; v.cr = cr; v.ccf = ccf; v.fcf = fcf; v.wcf = wcf;
    v.exp = {st, wel, rel};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    host.CE = v.ce; host.ALE = v.ale; host.CLE = v.cle; host.command = v.cmd;
    host.address_ready = v.ar; host.command_ready = v.cr;
    cache_count_flag = v.ccf; forming_count_flag = v.fcf; write_count_flag = v.wcf;
  endtask

  // Moore patterns {we, re, form, en_dec, en_sc, RB}
  localparam logic [5:0] P_IDLE = 6'b000001; // S0, S5, S7, S9
  localparam logic [5:0] P_ADDR = 6'b000101; // S1, S2, S3
  localparam logic [5:0] P_S4   = 6'b000010;
  localparam logic [5:0] P_S6   = 6'b001110;
  localparam logic [5:0] P_S8   = 6'b100110;
  localparam logic [5:0] P_S10  = 6'b010100;

  initial begin
    logic [7:0] e;
    // ce ale cle cmd ar cr ccf fcf wcf -> pattern WE_L RE_L
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,0,0, P_IDLE,1,1)); // 0  idle, no command
    vecs.push_back(mk(0,0,0,4'b0010,0,0,0,0,0, P_IDLE,1,1)); // 1  READ2 ignored in S0
    vecs.push_back(mk(0,0,1,4'b0111,0,0,0,0,0, P_ADDR,0,1)); // 2  FORM1 -> S3
    vecs.push_back(mk(0,1,0,4'b0000,0,0,0,0,0, P_ADDR,1,0)); // 3  hold S3, RE_L strobe
    vecs.push_back(mk(0,1,0,4'b0000,1,0,0,0,0, P_IDLE,1,1)); // 4  -> S5, RE_L released
    vecs.push_back(mk(0,0,0,4'b0100,0,0,0,0,0, P_IDLE,1,1)); // 5  wrong confirm holds S5
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,1,0, P_IDLE,1,1)); // 6  flag ignored in S5
    vecs.push_back(mk(0,0,0,4'b0110,0,0,0,0,0, P_S6,  1,1)); // 7  FORM2 -> S6
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,0,0, P_S6,  1,1)); // 8  wait in S6
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,1,0, P_IDLE,1,1)); // 9  done -> S0
    vecs.push_back(mk(0,0,0,4'b0101,0,0,0,0,0, P_ADDR,1,1)); // 10 WRITE1 -> S2
    vecs.push_back(mk(0,0,0,4'b0000,1,0,0,0,0, P_S4,  1,1)); // 11 -> S4
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,0,1, P_S4,  1,1)); // 12 write flag ignored in S4
    vecs.push_back(mk(0,0,0,4'b0000,0,0,1,0,0, P_IDLE,1,1)); // 13 cache full -> S7
    vecs.push_back(mk(0,0,0,4'b0010,0,0,0,0,0, P_IDLE,1,1)); // 14 READ2 holds S7
    vecs.push_back(mk(0,0,0,4'b0100,0,0,0,0,0, P_S8,  1,1)); // 15 WRITE2 -> S8
    vecs.push_back(mk(0,0,0,4'b0000,0,0,0,0,1, P_IDLE,1,1)); // 16 done -> S0
    vecs.push_back(mk(0,1,1,4'b0011,0,0,0,0,0, P_ADDR,0,0)); // 17 READ1 -> S1, both strobes
    vecs.push_back(mk(0,0,0,4'b0000,1,0,0,0,0, P_IDLE,1,1)); // 18 -> S9
    vecs.push_back(mk(0,0,0,4'b0000,0,1,0,0,0, P_IDLE,1,1)); // 19 command_ready ignored in S9
    vecs.push_back(mk(0,0,0,4'b0010,0,0,0,0,0, P_S10, 1,1)); // 20 READ2 -> S10
    vecs.push_back(mk(0,0,0,4'b0000,0,1,0,0,0, P_IDLE,1,1)); // 21 host done -> S0
    vecs.push_back(mk(0,0,0,4'b0111,0,0,0,0,0, P_ADDR,1,1)); // 22 FORM1 -> S3
    vecs.push_back(mk(0,0,0,4'b0000,1,0,0,0,0, P_IDLE,1,1)); // 23 -> S5
    vecs.push_back(mk(0,0,0,4'b0110,0,0,0,0,0, P_S6,  1,1)); // 24 -> S6
    vecs.push_back(mk(1,1,1,4'b0000,0,0,0,0,0, P_IDLE,1,1)); // 25 CE abort, strobes gated
    vecs.push_back(mk(0,0,0,4'b0101,0,0,0,0,0, P_ADDR,1,1)); // 26 WRITE1 -> S2
    vecs.push_back(mk(0,0,0,4'b0000,1,0,0,0,0, P_S4,  1,1)); // 27 -> S4
    vecs.push_back(mk(0,0,0,4'b0000,0,0,1,0,0, P_IDLE,1,1)); // 28 -> S7
    vecs.push_back(mk(0,0,0,4'b0100,0,0,0,0,0, P_S8,  1,1)); // 29 -> S8

    rst_n = 1'b0;
    drive(mk(1,0,0,4'b0000,0,0,0,0,0, P_IDLE,1,1));
    #12;
    check("reset", observed(), {P_IDLE, 1'b1, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d", i), observed(), e);
    end

    // Asynchronous reset while in S8: outputs must drop before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_S8", observed(), {P_IDLE, 1'b1, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0,0,0,4'b0000,0,0,0,0,0, P_IDLE,1,1));
    sb.push_back({P_IDLE, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("post_reset_idle", observed(), e);

    // WE_L follows CE/CLE combinationally, no clock edge needed.
    @(negedge clk);
    host.CLE = 1'b1;
    #1;
    check("we_l_comb", observed(), {P_IDLE, 1'b0, 1'b1});
    host.CE = 1'b1;
    #1;
    check("we_l_ce_gate", observed(), {P_IDLE, 1'b1, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
